// File: rtl/host_cmd_ctl_if.sv
`default_nettype none
// ============================================================================
// host_cmd_ctl_if : SPI byte stream in, RAM port-B control and MISO byte out
// Revision 1.0
// ============================================================================
interface host_cmd_ctl_if #(
    parameter int XLEN = 32
);
    logic            dc_i;
    logic            spi_byte_vld_i;
    logic [7:0]      spi_byte_data_i;
    logic [7:0]      ram_rd_data_i;
    logic            cpu_rst_n_o;
    logic            iram_rd_sel_o;
    logic            iram_wr_sel_o;
    logic            dram_rd_sel_o;
    logic            dram_wr_sel_o;
    logic [XLEN-1:0] ram_rw_addr_o;
    logic [3:0]      ram_wr_byte_en_o;
    logic [7:0]      spi_byte_data_o;

    modport slave (
        input  dc_i, spi_byte_vld_i, spi_byte_data_i, ram_rd_data_i,
        output cpu_rst_n_o, iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o,
               dram_wr_sel_o, ram_rw_addr_o, ram_wr_byte_en_o, spi_byte_data_o
    );

    modport master (
        output dc_i, spi_byte_vld_i, spi_byte_data_i, ram_rd_data_i,
        input  cpu_rst_n_o, iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o,
               dram_wr_sel_o, ram_rw_addr_o, ram_wr_byte_en_o, spi_byte_data_o
    );
endinterface
`default_nettype wire

// File: rtl/host_cmd_ctl.sv
`default_nettype none
// ============================================================================
// host_cmd_ctl : host command sequencer for CPU reset and IRAM/DRAM load/readback
// Revision 1.0
// ============================================================================
module host_cmd_ctl #(
    parameter int XLEN = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n_i,
    host_cmd_ctl_if.slave     bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_CTL  = 3'd1,
        ST_SET_ADDR = 3'd2,
        ST_IRAM_WR  = 3'd3,
        ST_IRAM_RD  = 3'd4,
        ST_DRAM_WR  = 3'd5,
        ST_DRAM_RD  = 3'd6,
        ST_STATUS   = 3'd7
    } state_t;

    localparam logic [7:0] C_CMD_CPU_RST  = 8'h2A;
    localparam logic [7:0] C_CMD_CPU_RUN  = 8'h2B;
    localparam logic [7:0] C_CMD_IRAM_WR  = 8'h2C;
    localparam logic [7:0] C_CMD_IRAM_RD  = 8'h2D;
    localparam logic [7:0] C_CMD_DRAM_WR  = 8'h2E;
    localparam logic [7:0] C_CMD_DRAM_RD  = 8'h2F;
    localparam logic [7:0] C_CMD_SET_ADDR = 8'h30;
    localparam logic [7:0] C_CMD_STATUS   = 8'h31;
    localparam logic [XLEN-1:0] C_ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_cpu_run;
    logic            w_cpu_run_nxt;
    logic            r_wr_seen;
    logic [XLEN-1:0] r_base;
    logic [XLEN-9:0] r_shadow;      // upper bytes of the shadow; the newest byte arrives live
    logic [XLEN-1:0] w_shadow_nxt;
    logic [1:0]      r_cnt;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic            r_wr_pend;
    logic            r_cpu_rst_n;
    logic            r_iram_wr_sel;
    logic            r_iram_rd_sel;
    logic            r_dram_wr_sel;
    logic            r_dram_rd_sel;
    logic            w_cmd;
    logic            w_dat;
    logic            w_ram_nxt;
    logic            w_is_wr;
    logic            w_is_rd;
    logic [7:0]      w_miso;

    assign w_cmd        = bus.spi_byte_vld_i & ~bus.dc_i;
    assign w_dat        = bus.spi_byte_vld_i &  bus.dc_i;
    assign w_shadow_nxt = {bus.spi_byte_data_i, r_shadow};
    assign w_is_wr      = (r_state == ST_IRAM_WR) || (r_state == ST_DRAM_WR);
    assign w_is_rd      = (r_state == ST_IRAM_RD) || (r_state == ST_DRAM_RD);
    assign w_ram_nxt    = (w_state_nxt == ST_IRAM_WR) || (w_state_nxt == ST_IRAM_RD) ||
                          (w_state_nxt == ST_DRAM_WR) || (w_state_nxt == ST_DRAM_RD);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commands preempt every state, including an unfinished address load
    always_comb begin
        w_state_nxt   = r_state;
        w_cpu_run_nxt = r_cpu_run;
        if (w_cmd) begin
            case (bus.spi_byte_data_i)
                C_CMD_CPU_RST:  begin w_state_nxt = ST_IDLE; w_cpu_run_nxt = 1'b0; end
                C_CMD_CPU_RUN:  begin w_state_nxt = ST_IDLE; w_cpu_run_nxt = 1'b1; end
                C_CMD_IRAM_WR:  w_state_nxt = ST_IRAM_WR;
                C_CMD_IRAM_RD:  w_state_nxt = ST_IRAM_RD;
                C_CMD_DRAM_WR:  w_state_nxt = ST_DRAM_WR;
                C_CMD_DRAM_RD:  w_state_nxt = ST_DRAM_RD;
                C_CMD_SET_ADDR: w_state_nxt = ST_SET_ADDR;
                C_CMD_STATUS:   w_state_nxt = ST_STATUS;
                default:        w_state_nxt = ST_IDLE;
            endcase
        end else if (w_dat && (r_state == ST_SET_ADDR) && (r_cnt == 2'd3)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cpu_run     <= 1'b0;
            r_wr_seen     <= 1'b0;
            r_base        <= '0;
            r_shadow      <= '0;
            r_cnt         <= 2'd0;
            r_addr        <= '0;
            r_be          <= 4'b0000;
            r_wr_pend     <= 1'b0;
            r_cpu_rst_n   <= 1'b0;
            r_iram_wr_sel <= 1'b0;
            r_iram_rd_sel <= 1'b0;
            r_dram_wr_sel <= 1'b0;
            r_dram_rd_sel <= 1'b0;
        end else begin
            r_be          <= 4'b0000;
            r_wr_pend     <= 1'b0;
            r_cpu_run     <= w_cpu_run_nxt;
            r_cpu_rst_n   <= w_cpu_run_nxt & ~w_ram_nxt;
            r_iram_wr_sel <= (w_state_nxt == ST_IRAM_WR);
            r_iram_rd_sel <= (w_state_nxt == ST_IRAM_RD);
            r_dram_wr_sel <= (w_state_nxt == ST_DRAM_WR);
            r_dram_rd_sel <= (w_state_nxt == ST_DRAM_RD);

            // Post-write increment runs one cycle behind the enable pulse
            if (r_wr_pend) begin
                r_addr    <= r_addr + C_ONE;
                r_wr_seen <= 1'b1;
            end

            if (w_cmd) begin
                if (bus.spi_byte_data_i == C_CMD_CPU_RUN) begin
                    r_wr_seen <= 1'b0;
                end
                if (w_ram_nxt) begin
                    r_addr <= r_base;
                end
                if (bus.spi_byte_data_i == C_CMD_SET_ADDR) begin
                    r_cnt <= 2'd0;
                end
            end else if (w_dat) begin
                if (w_is_wr) begin
                    r_be      <= 4'b0001 << r_addr[1:0];
                    r_wr_pend <= 1'b1;
                end else if (w_is_rd) begin
                    r_addr <= r_addr + C_ONE;
                end else if (r_state == ST_SET_ADDR) begin
                    r_shadow <= w_shadow_nxt[XLEN-1:8];
                    r_cnt    <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_base <= w_shadow_nxt;
                    end
                end
            end
        end
    end

    always_comb begin
        w_miso = 8'h00;
        if (w_is_rd) begin
            w_miso = bus.ram_rd_data_i;
        end else if (r_state == ST_STATUS) begin
            w_miso = {r_cpu_run, r_wr_seen, 2'b00, 4'hA};
        end
    end

    assign bus.cpu_rst_n_o      = r_cpu_rst_n;
    assign bus.iram_wr_sel_o    = r_iram_wr_sel;
    assign bus.iram_rd_sel_o    = r_iram_rd_sel;
    assign bus.dram_wr_sel_o    = r_dram_wr_sel;
    assign bus.dram_rd_sel_o    = r_dram_rd_sel;
    assign bus.ram_rw_addr_o    = r_addr;
    assign bus.ram_wr_byte_en_o = r_be;
    assign bus.spi_byte_data_o  = w_miso;
endmodule
`default_nettype wire

// File: tb/tb_host_cmd_ctl.sv
`default_nettype none
// ============================================================================
// tb_host_cmd_ctl : directed stimulus with a queued scoreboard for RAM traffic
// Revision 1.0
// ============================================================================
module tb_host_cmd_ctl;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic        rd;
        logic [3:0]  sel;      // {iram_wr, iram_rd, dram_wr, dram_rd}
        logic [31:0] addr;
        logic [3:0]  be;
        logic [7:0]  data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem_i [256];
    logic [7:0] mem_d [256];

    host_cmd_ctl_if #(.XLEN(32)) u_if ();

    host_cmd_ctl #(.XLEN(32)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM port-B model: one-cycle synchronous read, byte-wide write
    always @(posedge clk) begin
        if (|u_if.ram_wr_byte_en_o) begin
            if (u_if.iram_wr_sel_o) mem_i[u_if.ram_rw_addr_o[7:0]] <= u_if.spi_byte_data_i;
            if (u_if.dram_wr_sel_o) mem_d[u_if.ram_rw_addr_o[7:0]] <= u_if.spi_byte_data_i;
        end
        u_if.ram_rd_data_i <= u_if.iram_rd_sel_o ? mem_i[u_if.ram_rw_addr_o[7:0]]
                                                 : mem_d[u_if.ram_rw_addr_o[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] sels();
        return {u_if.iram_wr_sel_o, u_if.iram_rd_sel_o, u_if.dram_wr_sel_o, u_if.dram_rd_sel_o};
    endfunction

    // Monitor: write enables and read-phase data bytes each consume one queued entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (|u_if.ram_wr_byte_en_o)) begin
            if (q.size() == 0) begin
                chk("unexpected_wr_en", {28'd0, u_if.ram_wr_byte_en_o}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("wr_kind", {31'd0, e.rd}, 32'd0);
                chk("wr_addr", u_if.ram_rw_addr_o, e.addr);
                chk("wr_be", {28'd0, u_if.ram_wr_byte_en_o}, {28'd0, e.be});
                chk("wr_sel", {28'd0, sels()}, {28'd0, e.sel});
            end
        end
        if (rst_n && u_if.spi_byte_vld_i && u_if.dc_i && (u_if.iram_rd_sel_o || u_if.dram_rd_sel_o)) begin
            if (q.size() == 0) begin
                chk("unexpected_rd", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rd_kind", {31'd0, e.rd}, 32'd1);
                chk("rd_addr", u_if.ram_rw_addr_o, e.addr);
                chk("rd_data", {24'd0, u_if.spi_byte_data_o}, {24'd0, e.data});
                chk("rd_sel", {28'd0, sels()}, {28'd0, e.sel});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the edge that sampled the byte
    task automatic send(input logic dc, input logic [7:0] b);
        idle(16);
        u_if.dc_i            = dc;
        u_if.spi_byte_data_i = b;
        u_if.spi_byte_vld_i  = 1'b1;
        @(posedge clk);
        #1;
        u_if.spi_byte_vld_i  = 1'b0;
    endtask

    task automatic push(input logic rd, input logic [3:0] sel, input logic [31:0] a,
                        input logic [3:0] be, input logic [7:0] d);
        exp_t e;
        e = '{rd: rd, sel: sel, addr: a, be: be, data: d};
        q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst_n"}, {31'd0, u_if.cpu_rst_n_o}, 32'd0);
        chk({tag, "_sels"}, {28'd0, sels()}, 32'd0);
        chk({tag, "_addr"}, u_if.ram_rw_addr_o, 32'd0);
        chk({tag, "_be"}, {28'd0, u_if.ram_wr_byte_en_o}, 32'd0);
        chk({tag, "_miso"}, {24'd0, u_if.spi_byte_data_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wdat [5];
        logic [3:0] wbe  [5];
        wdat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        wbe  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n                = 1'b0;
        u_if.dc_i            = 1'b0;
        u_if.spi_byte_vld_i  = 1'b0;
        u_if.spi_byte_data_i = 8'h00;
        idle(4);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        send(1'b0, 8'h2B);
        chk("run_cpu_rst_n", {31'd0, u_if.cpu_rst_n_o}, 32'd1);
        send(1'b0, 8'h2A);
        chk("halt_cpu_rst_n", {31'd0, u_if.cpu_rst_n_o}, 32'd0);

        // Base 0x10, then five IRAM writes crossing a word boundary
        send(1'b0, 8'h30);
        send(1'b1, 8'h10); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00);
        send(1'b0, 8'h2C);
        chk("iwr_start_addr", u_if.ram_rw_addr_o, 32'h10);
        chk("iwr_sel", {28'd0, sels()}, 32'b1000);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 4'b1000, 32'h10 + i, wbe[i], wdat[i]);
            send(1'b1, wdat[i]);
            chk("iwr_cpu_held", {31'd0, u_if.cpu_rst_n_o}, 32'd0);
        end
        idle(2);
        chk("iwr_end_addr", u_if.ram_rw_addr_o, 32'h15);

        send(1'b0, 8'h2D);
        chk("ird_start_addr", u_if.ram_rw_addr_o, 32'h10);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 4'b0100, 32'h10 + i, 4'b0000, wdat[i]);
            send(1'b1, 8'h00);
        end
        idle(2);
        chk("ird_end_addr", u_if.ram_rw_addr_o, 32'h15);

        // Aborted address load keeps the old base
        send(1'b0, 8'h30);
        send(1'b1, 8'h55); send(1'b1, 8'h66);
        send(1'b0, 8'h2E);
        chk("partial_base_addr", u_if.ram_rw_addr_o, 32'h10);
        chk("dwr_sel", {28'd0, sels()}, 32'b0010);

        send(1'b0, 8'h30);
        for (int i = 0; i < 4; i++) send(1'b1, 8'hFF);
        send(1'b0, 8'h2E);
        chk("wrap_start_addr", u_if.ram_rw_addr_o, 32'hFFFF_FFFF);
        push(1'b0, 4'b0010, 32'hFFFF_FFFF, 4'b1000, 8'h11);
        send(1'b1, 8'h11);
        push(1'b0, 4'b0010, 32'h0000_0000, 4'b0001, 8'h22);
        send(1'b1, 8'h22);
        idle(2);
        chk("wrap_end_addr", u_if.ram_rw_addr_o, 32'h1);

        // Status byte and CPU reset release after leaving a RAM state
        send(1'b0, 8'h2B);
        chk("run2_cpu_rst_n", {31'd0, u_if.cpu_rst_n_o}, 32'd1);
        send(1'b0, 8'h2C);
        chk("ram_cpu_held", {31'd0, u_if.cpu_rst_n_o}, 32'd0);
        push(1'b0, 4'b1000, 32'hFFFF_FFFF, 4'b1000, 8'h77);
        send(1'b1, 8'h77);
        send(1'b0, 8'h31);
        chk("status_run", {24'd0, u_if.spi_byte_data_o}, 32'hCA);
        chk("status_cpu_restored", {31'd0, u_if.cpu_rst_n_o}, 32'd1);
        send(1'b0, 8'h2A);
        send(1'b0, 8'h31);
        chk("status_halt", {24'd0, u_if.spi_byte_data_o}, 32'h4A);

        // Asynchronous reset during a DRAM write data byte
        send(1'b0, 8'h2E);
        idle(16);
        u_if.dc_i            = 1'b1;
        u_if.spi_byte_data_i = 8'h99;
        u_if.spi_byte_vld_i  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        #1;
        u_if.spi_byte_vld_i = 1'b0;
        idle(3);
        chk("rst_no_be", {28'd0, u_if.ram_wr_byte_en_o}, 32'd0);
        rst_n = 1'b1;

        send(1'b0, 8'h55);
        send(1'b1, 8'h12);
        chk("unk_sels", {28'd0, sels()}, 32'd0);
        chk("unk_be", {28'd0, u_if.ram_wr_byte_en_o}, 32'd0);
        idle(4);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/host_cmd_ctl.md
# host_cmd_ctl

Host-side command sequencer between `spi_slave` and `ram`: decodes SPI command/data bytes framed by `dc_i`, controls CPU reset and drives the RAM port-B address, selects and byte enables for host IRAM/DRAM load and readback. It adds to the basic load path a loadable base address, explicit CPU run/halt and a status readback byte returned on MISO. It replaces the host-side RAM sequencing in the SoC top.

## Interface
- XLEN, 32, address/data width; only 32 supported (SET_ADDR loads 4 bytes).

- clk_i  in  1  system clock
- rst_n_i  in  1  reset; asynchronous, active-low
- dc_i  in  1  0 = command byte, 1 = data byte; sampled with `spi_byte_vld_i`
- spi_byte_vld_i  in  1  one-cycle pulse, received byte valid
- spi_byte_data_i  in  8  received byte; held stable until next byte
- ram_rd_data_i  in  8  byte lane read from RAM port B, 1-cycle synchronous latency
- cpu_rst_n_o  out  1  CPU reset, active-low
- iram_rd_sel_o / iram_wr_sel_o / dram_rd_sel_o / dram_wr_sel_o  out  1 each  port-B selects; at most one high
- ram_rw_addr_o  out  XLEN  port-B byte address
- ram_wr_byte_en_o  out  4  port-B write byte enable, one-hot or zero
- spi_byte_data_o  out  8  next byte to shift out on MISO

## Operation
- States: IDLE, CPU_CTL, SET_ADDR, IRAM_WR, IRAM_RD, DRAM_WR, DRAM_RD, STATUS.
- Command byte (vld & !dc_i) always decodes, from any state, aborting any data phase:
  - 0x2A CPU_RST: cpu_run <= 0, state IDLE.
  - 0x2B CPU_RUN: cpu_run <= 1, wr_seen <= 0, state IDLE.
  - 0x2C/0x2D/0x2E/0x2F: IRAM_WR/IRAM_RD/DRAM_WR/DRAM_RD; ram_rw_addr_o <= base.
  - 0x30: SET_ADDR, byte counter <= 0.
  - 0x31: STATUS.
  - other: IDLE.
- Data byte (vld & dc_i):
  - WR states: next cycle ram_wr_byte_en_o = 1 << ram_rw_addr_o[1:0] for exactly one cycle; the cycle after, address += 1; wr_seen <= 1.
  - RD states: address += 1 one cycle after vld.
  - SET_ADDR: shadow <= {byte, shadow[31:8]} (little-endian). On the 4th byte, base <= shadow value, state IDLE. A partial load aborted by a command leaves base unchanged. Data bytes in IDLE/STATUS are ignored.
- Address wraps 0xFFFF_FFFF -> 0. base is never modified by accesses.
- cpu_rst_n_o = cpu_run & not in any of the four RAM states (registered). The CPU is held in reset during any host RAM access and returns to the cpu_run level on leaving the RAM state.
- spi_byte_data_o (combinational mux):
  - RD states: ram_rd_data_i.
  - STATUS: {cpu_run, wr_seen, 2'b00, 4'hA}.
  - else: 8'h00.
- Selects are registered decodes of the state.

## Timing
- Reset values:
  - state IDLE; cpu_run 0; wr_seen 0; base 0; shadow 0.
  - cpu_rst_n_o 0; all selects 0; ram_rw_addr_o 0; ram_wr_byte_en_o 0; spi_byte_data_o 0x00.
- Command decode: state, selects and address valid in the cycle after the vld pulse (1-cycle latency).
- Write: byte enable 1 cycle after vld; address increment 2 cycles after vld. Back-to-back vld pulses are ≥ 16 clk apart (SPI byte time), so no overlap.
- Read: the address for byte n+1 is valid 1 cycle after byte n's vld, and RAM data 1 cycle later. spi_byte_data_o is valid 2 cycles after vld, well before the next byte's first shift.
- Reset asserted mid-operation aborts immediately to the reset values; no partial write completes after reset.
- A command arriving during a pending write-enable cycle: the enable still issues for the old address, and the new state takes effect in the same cycle.

## Test plan
- Reset, then 0x2B: cpu_rst_n_o 0 after reset -> 1 one cycle after vld. Then 0x2A -> 0.
- 0x30, data 0x10,0x00,0x00,0x00, then 0x2C, data 0xAA,0xBB,0xCC,0xDD,0xEE -> writes at 0x10..0x14 with byte_en 0001,0010,0100,1000,0001. iram_wr_sel_o high throughout; cpu_rst_n_o 0 during, restored to cpu_run after the next command.
- 0x2D after the above, 5 data bytes -> address sequence 0x10..0x15 and spi_byte_data_o returns 0xAA,0xBB,0xCC,0xDD,0xEE on successive bytes.
- 0x30 with only 2 data bytes, then 0x2E -> DRAM address starts at old base 0x10; then a full SET_ADDR of 0xFFFFFFFF followed by 0x2E and 2 bytes -> addresses 0xFFFFFFFF, 0x00000000.
- After 0x2B, 0x2C + 1 byte, then 0x31 -> status 0xCA; after 0x2A, 0x31 -> 0x4A.
- Assert rst_n_i mid DRAM_WR data byte -> all outputs at reset values asynchronously; no byte_en pulse afterwards; unknown command 0x55 followed by data -> no selects, no enables.
